// File: rtl/pc_unit.sv
// pc_unit: program-counter generator for the fetch stage.
// Holds the fetch PC, steps it on a valid/ready handshake and takes
// branch / JAL / JALR redirects from execute. Also provides a boot cycle
// after reset, a misaligned-target trap, EBREAK halt/resume and the
// link address (EXEC_PC + instruction size) for JAL/JALR.
// Optional feature macro: COMPRESSED_EN (2-byte alignment, 2/4-byte steps).

module pc_unit #(
    parameter int                 XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]    TRAP_VECTOR  = XLEN'('h100)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [XLEN-1:0]       o_pc,
    output logic                  o_pc_valid,
    input  logic                  i_fetch_ready,
    input  logic                  i_exec_valid,
    input  logic [XLEN-1:0]       i_exec_pc,
    input  logic [6:0]            i_opcode,
    input  logic [2:0]            i_func,
    input  logic [XLEN-1:0]       i_imm,
    input  logic [XLEN-1:0]       i_rs1,
    input  logic                  i_eq,
    input  logic                  i_lt_sn,
    input  logic                  i_lt_un,
    input  logic                  i_gt_sn,
    input  logic                  i_gt_un,
    input  logic                  i_resume,
`ifdef COMPRESSED_EN
    input  logic                  i_instr_is_c,
    input  logic                  i_exec_is_c,
`endif
    output logic [XLEN-1:0]       o_link,
    output logic                  o_misalign,
    output logic                  o_halted
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [XLEN-1:0] STEP_2 = XLEN'(2);
    localparam logic [XLEN-1:0] STEP_4 = XLEN'(4);
    localparam logic [XLEN-1:0] IMM_EBREAK = XLEN'(1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_next_pc;
    logic              r_misalign;
    logic              w_next_misalign;

    logic              w_is_branch;
    logic              w_is_jal;
    logic              w_is_jalr;
    logic              w_is_ebreak;
    logic              w_branch_taken;
    logic              w_redirect;
    logic              w_handshake;
    logic              w_target_misaligned;
    logic [XLEN-1:0]   w_pc_rel_target;
    logic [XLEN-1:0]   w_jalr_sum;
    logic [XLEN-1:0]   w_jalr_target;
    logic [XLEN-1:0]   w_target;
    logic [XLEN-1:0]   w_fetch_step;
    logic [XLEN-1:0]   w_exec_step;
    logic [XLEN-1:0]   w_link;

    // Decode the instruction sitting in execute.
    always_comb begin
        w_is_branch = (i_opcode == OP_BRANCH);
        w_is_jal    = (i_opcode == OP_JAL);
        w_is_jalr   = (i_opcode == OP_JALR);
        w_is_ebreak = i_exec_valid && (i_opcode == OP_SYSTEM) &&
                      (i_func == 3'b000) && (i_imm == IMM_EBREAK);
    end

    // Branch condition from funct3 and the execute comparator flags.
    always_comb begin
        w_branch_taken = 1'b0;
        case (i_func)
            3'b000:  w_branch_taken = i_eq;
            3'b001:  w_branch_taken = ~i_eq;
            3'b100:  w_branch_taken = i_lt_sn;
            3'b101:  w_branch_taken = i_gt_sn;
            3'b110:  w_branch_taken = i_lt_un;
            3'b111:  w_branch_taken = i_gt_un;
            default: w_branch_taken = 1'b0;
        endcase
    end

    // Redirect target; adders are XLEN wide so the carry drops off naturally.
    always_comb begin
        w_pc_rel_target = i_exec_pc + i_imm;
        w_jalr_sum      = i_rs1 + i_imm;
        w_jalr_target   = {w_jalr_sum[XLEN-1:1], 1'b0};
        w_target        = w_is_jalr ? w_jalr_target : w_pc_rel_target;
`ifdef COMPRESSED_EN
        w_target_misaligned = w_target[0];
`else
        w_target_misaligned = |w_target[1:0];
`endif
    end

    // Instruction sizes for sequential fetch and for the execute-stage link value.
    always_comb begin
`ifdef COMPRESSED_EN
        w_fetch_step = i_instr_is_c ? STEP_2 : STEP_4;
        w_exec_step  = i_exec_is_c  ? STEP_2 : STEP_4;
`else
        w_fetch_step = STEP_4;
        w_exec_step  = STEP_4;
`endif
        w_link = i_exec_pc + w_exec_step;
    end

    // Redirects and handshakes only count while the fetch side is running.
    always_comb begin
        w_redirect  = i_exec_valid && (r_state == ST_RUN) &&
                      ((w_is_branch && w_branch_taken) || w_is_jal || w_is_jalr);
        w_handshake = o_pc_valid && i_fetch_ready;
    end

    // Next state, next PC and trap pulse; redirect beats EBREAK beats sequential step.
    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = r_pc;
        w_next_misalign = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_redirect && w_target_misaligned) begin
                    w_next_pc       = TRAP_VECTOR;
                    w_next_misalign = 1'b1;
                end else if (w_redirect) begin
                    w_next_pc = w_target;
                end else if (w_is_ebreak) begin
                    w_next_state = ST_HALT;
                    w_next_pc    = w_link;
                end else if (w_handshake) begin
                    w_next_pc = r_pc + w_fetch_step;
                end
            end
            ST_HALT: begin
                if (i_resume) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_BOOT;
            end
        endcase
    end

    // State, PC and trap-pulse registers; reset drops any pending redirect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_misalign <= w_next_misalign;
        end
    end

    // Output mapping.
    always_comb begin
        o_pc       = r_pc;
        o_pc_valid = (r_state == ST_RUN);
        o_halted   = (r_state == ST_HALT);
        o_misalign = r_misalign;
        o_link     = w_link;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (default 4-byte build; the
// expected trap results adapt when COMPRESSED_EN is defined).

module tb_pc_unit;

    logic        clk;
    logic        rstN;
    logic [31:0] pc;
    logic        pcValid;
    logic        fetchReady;
    logic        execValid;
    logic [31:0] execPc;
    logic [6:0]  opcode;
    logic [2:0]  func;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        eq, ltSn, ltUn, gtSn, gtUn;
    logic        resume;
    logic [31:0] link;
    logic        misalign;
    logic        halted;
`ifdef COMPRESSED_EN
    logic        instrIsC;
    logic        execIsC;
`endif

    int numChecks;
    int numFails;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    pc_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .o_pc          (pc),
        .o_pc_valid    (pcValid),
        .i_fetch_ready (fetchReady),
        .i_exec_valid  (execValid),
        .i_exec_pc     (execPc),
        .i_opcode      (opcode),
        .i_func        (func),
        .i_imm         (imm),
        .i_rs1         (rs1),
        .i_eq          (eq),
        .i_lt_sn       (ltSn),
        .i_lt_un       (ltUn),
        .i_gt_sn       (gtSn),
        .i_gt_un       (gtUn),
        .i_resume      (resume),
`ifdef COMPRESSED_EN
        .i_instr_is_c  (instrIsC),
        .i_exec_is_c   (execIsC),
`endif
        .o_link        (link),
        .o_misalign    (misalign),
        .o_halted      (halted)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one execute-stage instruction.
    task automatic setExec(input logic [6:0] op, input logic [2:0] f,
                           input logic [31:0] epc, input logic [31:0] im,
                           input logic [31:0] r1);
        execValid = 1'b1;
        opcode    = op;
        func      = f;
        execPc    = epc;
        imm       = im;
        rs1       = r1;
    endtask

    task automatic clearExec();
        execValid = 1'b0;
        opcode    = 7'd0;
        func      = 3'd0;
        imm       = 32'd0;
        rs1       = 32'd0;
        {eq, ltSn, ltUn, gtSn, gtUn} = 5'b0;
    endtask

    // Reset values, boot cycle, mid-run async reset at PC=0x40.
    task automatic test_reset();
        rstN = 1'b0;
        #2;
        numChecks++;
        if (pc !== 32'h0 || pcValid !== 1'b0 || halted !== 1'b0 || misalign !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL reset_state: pc=%h valid=%b halted=%b mis=%b required 0/0/0/0", pc, pcValid, halted, misalign);
        end
        tick();
        rstN = 1'b1;
        // JAL in the boot cycle must be ignored
        setExec(OP_JAL, 3'd0, 32'h200, 32'h8, 32'h0);
        fetchReady = 1'b1;
        #1;
        numChecks++;
        if (pcValid !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL boot_valid: got %b required 0", pcValid);
        end
        tick();
        clearExec();
        numChecks++;
        if (pcValid !== 1'b1 || pc !== 32'h0) begin
            numFails++;
            $display("[TB] FAIL boot_exit: valid=%b pc=%h required 1/00000000", pcValid, pc);
        end
        for (int i = 0; i < 16; i++) tick();
        numChecks++;
        if (pc !== 32'h40) begin
            numFails++;
            $display("[TB] FAIL run_to_40: got %h required 00000040", pc);
        end
        rstN = 1'b0;
        #1;
        numChecks++;
        if (pc !== 32'h0 || pcValid !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL midrun_reset: pc=%h valid=%b required 00000000/0", pc, pcValid);
        end
        tick();
        rstN = 1'b1;
        tick();
        numChecks++;
        if (pcValid !== 1'b1 || pc !== 32'h0) begin
            numFails++;
            $display("[TB] FAIL reboot: valid=%b pc=%h required 1/00000000", pcValid, pc);
        end
    endtask

    // Stall at 0x8 for three cycles, then one accepted fetch.
    task automatic test_stall();
        fetchReady = 1'b1;
        tick();
        tick();
        fetchReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            numChecks++;
            if (pc !== 32'h8) begin
                numFails++;
                $display("[TB] FAIL stall_hold[%0d]: got %h required 00000008", i, pc);
            end
        end
        fetchReady = 1'b1;
        tick();
        fetchReady = 1'b0;
        numChecks++;
        if (pc !== 32'hC) begin
            numFails++;
            $display("[TB] FAIL stall_release: got %h required 0000000c", pc);
        end
    endtask

    // Conditional branches over several funct3 encodings.
    task automatic test_branch();
        setExec(OP_BRANCH, 3'b001, 32'h20, 32'hFFFF_FFF8, 32'h0);
        eq = 1'b0;
        #1;
        numChecks++;
        if (link !== 32'h24) begin
            numFails++;
            $display("[TB] FAIL link: got %h required 00000024", link);
        end
        tick();
        numChecks++;
        if (pc !== 32'h18) begin
            numFails++;
            $display("[TB] FAIL bne_taken: got %h required 00000018", pc);
        end
        eq = 1'b1;
        tick();
        numChecks++;
        if (pc !== 32'h18) begin
            numFails++;
            $display("[TB] FAIL bne_not_taken: got %h required 00000018", pc);
        end
        setExec(OP_BRANCH, 3'b000, 32'h40, 32'h10, 32'h0);
        tick();
        numChecks++;
        if (pc !== 32'h50) begin
            numFails++;
            $display("[TB] FAIL beq_taken: got %h required 00000050", pc);
        end
        eq = 1'b0;
        setExec(OP_BRANCH, 3'b110, 32'h100, 32'h20, 32'h0);
        ltUn = 1'b1;
        tick();
        numChecks++;
        if (pc !== 32'h120) begin
            numFails++;
            $display("[TB] FAIL bltu_taken: got %h required 00000120", pc);
        end
        setExec(OP_BRANCH, 3'b010, 32'h300, 32'h40, 32'h0);
        {eq, ltSn, ltUn, gtSn, gtUn} = 5'b11111;
        tick();
        numChecks++;
        if (pc !== 32'h120) begin
            numFails++;
            $display("[TB] FAIL func010_never: got %h required 00000120", pc);
        end
        clearExec();
    endtask

    // JAL, address wraparound on add and on sequential step.
    task automatic test_jal();
        setExec(OP_JAL, 3'd0, 32'h200, 32'h8, 32'h0);
        tick();
        numChecks++;
        if (pc !== 32'h208) begin
            numFails++;
            $display("[TB] FAIL jal: got %h required 00000208", pc);
        end
        setExec(OP_JAL, 3'd0, 32'hFFFF_FFF0, 32'h8, 32'h0);
        tick();
        clearExec();
        numChecks++;
        if (pc !== 32'hFFFF_FFF8) begin
            numFails++;
            $display("[TB] FAIL jal_high: got %h required fffffff8", pc);
        end
        fetchReady = 1'b1;
        tick();
        tick();
        fetchReady = 1'b0;
        numChecks++;
        if (pc !== 32'h0) begin
            numFails++;
            $display("[TB] FAIL step_wrap: got %h required 00000000", pc);
        end
        setExec(OP_JAL, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'h0);
        tick();
        clearExec();
        numChecks++;
        if (pc !== 32'h10) begin
            numFails++;
            $display("[TB] FAIL target_wrap: got %h required 00000010", pc);
        end
    endtask

    // JALR alignment and the misaligned-target trap.
    task automatic test_jalr_trap();
        logic [31:0] expJalr;
        logic [31:0] expJal;
        logic        expMis;
`ifdef COMPRESSED_EN
        expJalr = 32'h102;
        expJal  = 32'h22;
        expMis  = 1'b0;
`else
        expJalr = 32'h100;
        expJal  = 32'h100;
        expMis  = 1'b1;
`endif
        setExec(OP_JALR, 3'd0, 32'h60, 32'h0, 32'h103);
        tick();
        clearExec();
        numChecks++;
        if (pc !== expJalr || misalign !== expMis) begin
            numFails++;
            $display("[TB] FAIL jalr_trap: pc=%h mis=%b required %h/%b", pc, misalign, expJalr, expMis);
        end
        tick();
        numChecks++;
        if (misalign !== 1'b0 || pc !== expJalr) begin
            numFails++;
            $display("[TB] FAIL misalign_pulse: mis=%b pc=%h required 0/%h", misalign, pc, expJalr);
        end
        setExec(OP_JALR, 3'd0, 32'h60, 32'h7, 32'h1001);
        tick();
        numChecks++;
        if (pc !== 32'h1008 || misalign !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL jalr_aligned: pc=%h mis=%b required 00001008/0", pc, misalign);
        end
        setExec(OP_JAL, 3'd0, 32'h20, 32'h2, 32'h0);
        tick();
        clearExec();
        numChecks++;
        if (pc !== expJal || misalign !== expMis) begin
            numFails++;
            $display("[TB] FAIL jal_half_aligned: pc=%h mis=%b required %h/%b", pc, misalign, expJal, expMis);
        end
    endtask

    // Redirect colliding with a handshake, then consecutive redirects.
    task automatic test_back_to_back();
        fetchReady = 1'b1;
        setExec(OP_JAL, 3'd0, 32'h70, 32'h10, 32'h0);
        tick();
        numChecks++;
        if (pc !== 32'h80) begin
            numFails++;
            $display("[TB] FAIL collision: got %h required 00000080", pc);
        end
        setExec(OP_JAL, 3'd0, 32'h300, 32'h0, 32'h0);
        tick();
        setExec(OP_JAL, 3'd0, 32'h400, 32'h4, 32'h0);
        numChecks++;
        if (pc !== 32'h300) begin
            numFails++;
            $display("[TB] FAIL b2b_first: got %h required 00000300", pc);
        end
        tick();
        clearExec();
        numChecks++;
        if (pc !== 32'h404) begin
            numFails++;
            $display("[TB] FAIL b2b_second: got %h required 00000404", pc);
        end
        tick();
        fetchReady = 1'b0;
        numChecks++;
        if (pc !== 32'h408) begin
            numFails++;
            $display("[TB] FAIL after_redirect_step: got %h required 00000408", pc);
        end
    endtask

    // EBREAK halt, ignored execute while halted, resume, reset out of halt.
    task automatic test_ebreak();
        fetchReady = 1'b1;
        setExec(OP_SYSTEM, 3'd0, 32'h500, 32'h0, 32'h0);
        tick();
        numChecks++;
        if (pc !== 32'h40C || halted !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL ecall_no_halt: pc=%h halted=%b required 0000040c/0", pc, halted);
        end
        setExec(OP_SYSTEM, 3'd0, 32'h30, 32'h1, 32'h0);
        tick();
        numChecks++;
        if (halted !== 1'b1 || pcValid !== 1'b0 || pc !== 32'h34) begin
            numFails++;
            $display("[TB] FAIL ebreak_halt: halted=%b valid=%b pc=%h required 1/0/00000034", halted, pcValid, pc);
        end
        setExec(OP_JAL, 3'd0, 32'h600, 32'h8, 32'h0);
        tick();
        tick();
        numChecks++;
        if (halted !== 1'b1 || pc !== 32'h34) begin
            numFails++;
            $display("[TB] FAIL halt_ignores_exec: halted=%b pc=%h required 1/00000034", halted, pc);
        end
        clearExec();
        fetchReady = 1'b0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        numChecks++;
        if (halted !== 1'b0 || pcValid !== 1'b1 || pc !== 32'h34) begin
            numFails++;
            $display("[TB] FAIL resume: halted=%b valid=%b pc=%h required 0/1/00000034", halted, pcValid, pc);
        end
        setExec(OP_SYSTEM, 3'd0, 32'h80, 32'h1, 32'h0);
        tick();
        clearExec();
        rstN = 1'b0;
        #1;
        numChecks++;
        if (halted !== 1'b0 || pc !== 32'h0 || pcValid !== 1'b0) begin
            numFails++;
            $display("[TB] FAIL reset_from_halt: halted=%b pc=%h valid=%b required 0/00000000/0", halted, pc, pcValid);
        end
        rstN = 1'b1;
    endtask

    // Test sequence.
    initial begin
        numChecks  = 0;
        numFails   = 0;
        rstN       = 1'b0;
        fetchReady = 1'b0;
        resume     = 1'b0;
        execPc     = 32'd0;
`ifdef COMPRESSED_EN
        instrIsC   = 1'b0;
        execIsC    = 1'b0;
`endif
        clearExec();
        test_reset();
        test_stall();
        test_branch();
        test_jal();
        test_jalr_trap();
        test_back_to_back();
        test_ebreak();
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
